cookie_jar: RTL and testbench

- Downstream consumer of the cookie crumb grid's serial random bit output.
- Optionally debiases the raw bit stream with a von Neumann corrector, then packs surviving bits into WIDTH-bit words.
- Buffers words in a small FIFO and hands them to the host/IO side over a valid/ready handshake.
- Flags lost words with a sticky overflow bit.

---
 rtl/cookie_pkg.sv | 16 +
 rtl/jar_fifo.sv | 74 +++++++
 rtl/cookie_jar.sv | 112 +++++++++++
 tb/tb_cookie_jar.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cookie_pkg.sv
// Shared types and constants for the cookie jar random-word packer.
package cookie_pkg;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } debias_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/jar_fifo.sv
// Show-ahead synchronous FIFO: head word visible the cycle after push into an empty FIFO.
// Push while full is accepted only when a pop happens on the same edge; otherwise it is refused.
module jar_fifo
  import cookie_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // A full FIFO can still take a word when the head leaves on the same edge.
  assign pop_ok  = pop_rdy && !empty;
  assign push_ok = push_vld && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cookie_jar.sv
// Debiases the grid's serial bits, packs them MSB-first into words and queues them for the host.
// Words appear on valid_o the cycle after completion; words completing into a full, non-draining FIFO are dropped and flagged.
module cookie_jar
  import cookie_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DEBIAS = 1,
  localparam int CW    = cnt_width(DEPTH),
  localparam int BCW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rbit,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  input  logic             clr_ovf
);

  debias_state_e    state_q, state_d;
  logic             a_q, a_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ovf_q, ovf_d;

  logic             emit;
  logic             ebit;
  logic             push_vld;
  logic [WIDTH-1:0] push_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    emit      = 1'b0;
    ebit      = 1'b0;
    push_vld  = 1'b0;
    if (en) begin
      if (DEBIAS != 0) begin
        if (state_q == FIRST) begin
          a_d     = rbit;
          state_d = SECOND;
        end else begin
          // Unequal pair yields its first bit; equal pairs carry no entropy.
          state_d = FIRST;
          emit    = (a_q != rbit);
          ebit    = a_q;
        end
      end else begin
        emit = 1'b1;
        ebit = rbit;
      end
    end
    if (emit) begin
      shreg_d = {shreg_q[WIDTH-2:0], ebit};
      if (bit_cnt_q == BCW'(WIDTH - 1)) begin
        push_vld  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end
    end
    push_dat = shreg_d;
  end

  // Set beats clear when a drop lands on the same edge as clr_ovf.
  assign drop  = push_vld && fifo_full && !(valid_o && ready_i);
  assign ovf_d = drop || (ovf_q && !clr_ovf);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FIRST;
      a_q       <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ovf_q     <= ovf_d;
    end
  end

  jar_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (ready_i),
    .head_dat (data_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count_o)
  );

  assign valid_o    = !fifo_empty;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cookie_jar.sv
// Drives a raw (DEBIAS=0) and a debiased (DEBIAS=1) jar side by side against a queue-based model.
module tb_cookie_jar;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en_v, rbit_v, rdy_v, clr_v;
  logic [1:0] vld_w, ovf_w;
  logic [7:0] dat_w [2];
  logic [2:0] cnt_w [2];

  int n_vec = 0;
  int n_err = 0;

  int         pend  [2];
  int         nb    [2];
  int         acc   [2];
  bit         ovf_m [2];
  logic [7:0] fq    [2][$];

  always #5 clk = ~clk;

  cookie_jar #(.WIDTH(8), .DEPTH(4), .DEBIAS(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rbit(rbit_v[0]),
    .data_o(dat_w[0]), .valid_o(vld_w[0]), .ready_i(rdy_v[0]),
    .count_o(cnt_w[0]), .overflow_o(ovf_w[0]), .clr_ovf(clr_v[0])
  );

  cookie_jar #(.WIDTH(8), .DEPTH(4), .DEBIAS(1)) u_vn (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rbit(rbit_v[1]),
    .data_o(dat_w[1]), .valid_o(vld_w[1]), .ready_i(rdy_v[1]),
    .count_o(cnt_w[1]), .overflow_o(ovf_w[1]), .clr_ovf(clr_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a pending-bit slot, a running word value and a bounded queue.
  task automatic model_edge(input int k);
    bit emit;
    int b;
    bit pop;
    if (!rst_n) begin
      pend[k] = -1; nb[k] = 0; acc[k] = 0; ovf_m[k] = 1'b0;
      fq[k].delete();
      return;
    end
    pop  = rdy_v[k] && (fq[k].size() > 0);
    emit = 1'b0;
    b    = 0;
    if (en_v[k]) begin
      if (k == 1) begin
        if (pend[k] < 0) pend[k] = int'(rbit_v[k]);
        else begin
          if (pend[k] != int'(rbit_v[k])) begin emit = 1'b1; b = pend[k]; end
          pend[k] = -1;
        end
      end else begin
        emit = 1'b1; b = int'(rbit_v[k]);
      end
    end
    if (pop) void'(fq[k].pop_front());
    if (clr_v[k]) ovf_m[k] = 1'b0;
    if (emit) begin
      acc[k] = acc[k] * 2 + b;
      nb[k]++;
      if (nb[k] == 8) begin
        if (fq[k].size() < 4) fq[k].push_back(8'(acc[k]));
        else ovf_m[k] = 1'b1;
        nb[k] = 0; acc[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), 32'(vld_w[k]), 32'(fq[k].size() > 0));
      chk($sformatf("count%0d", k), 32'(cnt_w[k]), 32'(fq[k].size()));
      chk($sformatf("ovf%0d", k), 32'(ovf_w[k]), 32'(ovf_m[k]));
      if (fq[k].size() > 0) chk($sformatf("data%0d", k), 32'(dat_w[k]), 32'(fq[k][0]));
    end
  endtask

  task automatic quiet();
    en_v = '0; rdy_v = '0; clr_v = '0;
    rbit_v = 2'($urandom);
  endtask

  task automatic feed_bit(input int k, input bit b, input bit rdy);
    quiet();
    en_v[k] = 1'b1; rbit_v[k] = b; rdy_v[k] = rdy;
    tick();
  endtask

  task automatic idle(input int k, input bit rdy, input bit clr);
    quiet();
    rdy_v[k] = rdy; clr_v[k] = clr;
    tick();
  endtask

  task automatic feed_word(input int k, input logic [7:0] w, input bit rdy_last);
    for (int i = 7; i >= 0; i--) feed_bit(k, w[i], (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic feed_pair(input bit a, input bit b, input bit rdy);
    feed_bit(1, a, rdy);
    feed_bit(1, b, rdy);
  endtask

  logic [7:0] exp_w;

  initial begin
    quiet();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(vld_w[0]), 32'd0);
    chk("rst_data", 32'(dat_w[0]), 32'd0);
    chk("rst_count", 32'(cnt_w[1]), 32'd0);
    chk("rst_ovf", 32'(ovf_w[1]), 32'd0);
    rst_n = 1'b1;

    // Raw bits 1,0,1,1,0,0,1,0 -> B2, popped on the next edge.
    exp_w = 8'hB2;
    for (int i = 7; i >= 0; i--) feed_bit(0, exp_w[i], 1'b1);
    chk("raw_b2_valid", 32'(vld_w[0]), 32'd1);
    chk("raw_b2_data", 32'(dat_w[0]), 32'hB2);
    idle(0, 1'b1, 1'b0);
    chk("raw_b2_drained", 32'(cnt_w[0]), 32'd0);

    // Debiased pairs 10,11,01,10,00,10,01,01,10,01 -> B2.
    feed_pair(1, 0, 1); feed_pair(1, 1, 1); feed_pair(0, 1, 1); feed_pair(1, 0, 1);
    feed_pair(0, 0, 1); feed_pair(1, 0, 1); feed_pair(0, 1, 1); feed_pair(0, 1, 1);
    feed_pair(1, 0, 1); feed_pair(0, 1, 1);
    chk("vn_b2_count", 32'(cnt_w[1]), 32'd1);
    chk("vn_b2_data", 32'(dat_w[1]), 32'hB2);
    idle(1, 1'b1, 1'b0);

    // Five words into a stalled FIFO: fifth is lost.
    for (int w = 1; w <= 5; w++) feed_word(0, 8'(w), 1'b0);
    chk("ovf_count", 32'(cnt_w[0]), 32'd4);
    chk("ovf_flag", 32'(ovf_w[0]), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      chk("drain_order", 32'(dat_w[0]), 32'(w));
      idle(0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(vld_w[0]), 32'd0);
    chk("ovf_sticky", 32'(ovf_w[0]), 32'd1);
    idle(0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf_w[0]), 32'd0);

    // Full FIFO with a pop on the completing edge accepts AA.
    feed_word(0, 8'h11, 1'b0); feed_word(0, 8'h22, 1'b0);
    feed_word(0, 8'h33, 1'b0); feed_word(0, 8'h44, 1'b0);
    feed_word(0, 8'hAA, 1'b1);
    chk("fullpop_count", 32'(cnt_w[0]), 32'd4);
    chk("fullpop_ovf", 32'(ovf_w[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_w = (i == 3) ? 8'hAA : 8'(8'h22 + 8'h11 * i);
      chk("fullpop_drain", 32'(dat_w[0]), 32'(exp_w));
      idle(0, 1'b1, 1'b0);
    end

    // Idle cycles inside a debias pair do not break it.
    feed_bit(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0); idle(1, 1'b0, 1'b0); idle(1, 1'b0, 1'b0);
    feed_bit(1, 1'b0, 1'b0);
    chk("gap_no_word", 32'(vld_w[1]), 32'd0);
    for (int i = 0; i < 7; i++) feed_pair(i[0] ? 1'b1 : 1'b0, i[0] ? 1'b0 : 1'b1, 1'b0);
    chk("gap_data", 32'(dat_w[1]), 32'hAA);
    chk("gap_count", 32'(cnt_w[1]), 32'd1);
    idle(1, 1'b1, 1'b0);

    // Reset mid-word discards the partial word.
    feed_bit(0, 1, 0); feed_bit(0, 0, 0); feed_bit(0, 1, 0); feed_bit(0, 0, 0); feed_bit(0, 1, 0);
    quiet(); rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) feed_bit(0, 1'b1, 1'b0);
    chk("rst_mid_data", 32'(dat_w[0]), 32'hFF);
    chk("rst_mid_count", 32'(cnt_w[0]), 32'd1);

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        en_v[k]   = ($urandom_range(0, 3) != 0);
        rbit_v[k] = ($urandom_range(0, 3) != 0);
        rdy_v[k]  = ($urandom_range(0, 2) == 0);
        clr_v[k]  = ($urandom_range(0, 15) == 0);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
